sp_capture_ctrl: RTL

//  Multi-channel successor to the single-channel spectrum-FIFO write controller.
//  - Accepts nWire sample-ready strobes from NUM_CH receivers and selects one channel.
//  - Optionally decimates the selected strobes, then writes one block of block_len samples into SP_fifo.
//  - Modes: free-run (refill whenever the FIFO drains) or one-shot (host arm).
//  - Sits between the Atlas A12 nWire receivers and SP_fifo on the IF clock domain.

---
 rtl/sp_capture_pkg.sv | 18 +
 rtl/sp_capture_ctrl_if.sv | 27 ++
 rtl/sp_strobe_edge.sv | 25 ++
 rtl/sp_capture_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sp_capture_pkg.sv
// Shared constants for the multi-channel spectrum capture controller:
// FSM encoding, capture modes and the channel-select width helper.
package sp_capture_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_EMPTY = 2'd1;
    localparam logic [1:0] ST_FILL       = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

    localparam logic MODE_FREERUN = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // A single receiver still needs a 1-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sp_capture_ctrl_if.sv
// nWire strobe handshake and SP_fifo write-side signals between the
// receivers, the capture controller and the FIFO.
interface sp_capture_ctrl_if #(
    parameter int NUM_CH = 2
) ();
    logic [NUM_CH-1:0] spd_rdy;
    logic [NUM_CH-1:0] spd_ack;
    logic              fifo_wrempty;
    logic              fifo_wrfull;
    logic              write;

    modport master (
        input  spd_rdy,
        input  fifo_wrempty,
        input  fifo_wrfull,
        output spd_ack,
        output write
    );

    modport slave (
        output spd_rdy,
        output fifo_wrempty,
        output fifo_wrfull,
        input  spd_ack,
        input  write
    );
endinterface

// File: rtl/sp_strobe_edge.sv
// One receiver's rdy -> ack stage; pulse marks the first clock of each rdy level.
module sp_strobe_edge (
    input  logic clk,
    input  logic reset,
    input  logic rdy_i,
    output logic ack_o,
    output logic pulse_o
);
    logic ack_q;
    logic pulse_q;

    // ack follows rdy one clock later; rising edge is rdy high while ack still low
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            ack_q   <= rdy_i;
            pulse_q <= rdy_i & ~ack_q;
        end
    end

    assign ack_o   = ack_q;
    assign pulse_o = pulse_q;
endmodule

// File: rtl/sp_capture_ctrl.sv
// Selects one nWire receiver, decimates its strobes and writes one block of
// samples into SP_fifo per free-run refill or one-shot arm.
module sp_capture_ctrl
    import sp_capture_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 12,
    parameter int DEC_W  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    sp_capture_ctrl_if.master                bus,
    input  logic [sel_width(NUM_CH)-1:0]     ch_sel,
    input  logic                             mode,
    input  logic                             arm,
    input  logic [CNT_W-1:0]                 block_len,
    input  logic [DEC_W-1:0]                 decim,
    output logic                             busy,
    output logic                             done,
    output logic                             short_blk
);
    localparam int SEL_W = sel_width(NUM_CH);

    logic [NUM_CH-1:0] ack_s;
    logic [NUM_CH-1:0] pulse_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_edge
        sp_strobe_edge u_edge (
            .clk     (clk),
            .reset   (reset),
            .rdy_i   (bus.spd_rdy[g]),
            .ack_o   (ack_s[g]),
            .pulse_o (pulse_s[g])
        );
    end
    assign bus.spd_ack = ack_s;

    logic [1:0]       state_q,     state_d;
    logic [SEL_W-1:0] ch_sel_q,    ch_sel_d;
    logic [CNT_W-1:0] block_len_q, block_len_d;
    logic [DEC_W-1:0] decim_q,     decim_d;
    logic [CNT_W-1:0] samp_cnt_q,  samp_cnt_d;
    logic [DEC_W-1:0] dec_cnt_q,   dec_cnt_d;
    logic             write_q,     write_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             short_q,     short_d;
    logic             sel_pulse_q;
    logic [CNT_W-1:0] samp_inc_s;

    // Wrap at CNT_W bits so block_len = 0 completes after 2**CNT_W writes.
    assign samp_inc_s = samp_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state, latch and counter logic for the capture FSM
    always_comb begin
        state_d     = state_q;
        ch_sel_d    = ch_sel_q;
        block_len_d = block_len_q;
        decim_d     = decim_q;
        samp_cnt_d  = samp_cnt_q;
        dec_cnt_d   = dec_cnt_q;
        write_d     = 1'b0;
        short_d     = short_q;
        case (state_q)
            ST_IDLE: begin
                if ((mode == MODE_FREERUN) || arm) begin
                    state_d = ST_WAIT_EMPTY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_EMPTY: begin
                if (bus.fifo_wrempty) begin
                    ch_sel_d    = (32'(ch_sel) < NUM_CH) ? ch_sel : {SEL_W{1'b0}};
                    block_len_d = block_len;
                    decim_d     = decim;
                    samp_cnt_d  = {CNT_W{1'b0}};
                    dec_cnt_d   = {DEC_W{1'b0}};
                    state_d     = ST_FILL;
                end else begin
                    state_d = ST_WAIT_EMPTY;
                end
            end
            ST_FILL: begin
                if (bus.fifo_wrfull) begin
                    short_d = 1'b1;
                    state_d = ST_DONE;
                end else if (sel_pulse_q) begin
                    if (dec_cnt_q == decim_q) begin
                        write_d    = 1'b1;
                        dec_cnt_d  = {DEC_W{1'b0}};
                        samp_cnt_d = samp_inc_s;
                        if (samp_inc_s == block_len_q) begin
                            short_d = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        dec_cnt_d = dec_cnt_q + {{(DEC_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_WAIT_EMPTY) || (state_d == ST_FILL);
        done_d = (state_d == ST_DONE);
    end

    // State, latched configuration, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ch_sel_q    <= {SEL_W{1'b0}};
            block_len_q <= {CNT_W{1'b0}};
            decim_q     <= {DEC_W{1'b0}};
            samp_cnt_q  <= {CNT_W{1'b0}};
            dec_cnt_q   <= {DEC_W{1'b0}};
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            sel_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_sel_q    <= ch_sel_d;
            block_len_q <= block_len_d;
            decim_q     <= decim_d;
            samp_cnt_q  <= samp_cnt_d;
            dec_cnt_q   <= dec_cnt_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            short_q     <= short_d;
            sel_pulse_q <= pulse_s[ch_sel_q];
        end
    end

    assign bus.write = write_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign short_blk = short_q;
endmodule
